id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//   Hazard/forwarding controller for the ID stage. Tracks the destination register, write-enable
//   and load flag of the instruction held in EX, ME and WB using its own stage slots, updated by
//   each stage's advance handshake. Drives the ID load-use stall and per-operand forward selects.
//   ID uses these to choose between regfile data and the EX/ME/WB forward results.
// PARAMETERS
//   REG_AW   5    register address width; address 0 is hard-wired zero and never matches
//   CNT_W    32   perf counter width (only with HAZ_PERF_CNT_EN)
// PORTS
//   clk            in   1       clock
//   resetn         in   1       async active-low reset
//   id_issue       in   1       ID->EX fire (ID_to_EX_Valid & EX_Allow_in)
//   id_dest        in   REG_AW  dest of issuing instr
//   id_gr_we       in   1       issuing instr writes GR
//   id_is_load     in   1       issuing instr is a load
//   ex_fire        in   1       EX->ME fire
//   me_fire        in   1       ME->WB fire
//   wb_retire      in   1       WB instr retires (regfile write cycle)
//   id_valid       in   1       ID holds a valid instr
//   rj_addr        in   REG_AW  ID source 1
//   rj_use         in   1       source 1 is read
//   rkd_addr       in   REG_AW  ID source 2 (rk or rd)
//   rkd_use        in   1       source 2 is read
//   ld_stall       out  1       hold ID this cycle
//   fwd_sel_rj     out  2       HAZ_FWD_RF/EX/ME/WB for source 1
//   fwd_sel_rkd    out  2       same encoding for source 2
//   perf_stall_cnt out  CNT_W   stall cycles (HAZ_PERF_CNT_EN only)
//   perf_issue_cnt out  CNT_W   issued instrs (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//   - Slot = {v, dest, we, ld}. Reset (async, resetn=0): all v=0, dest=0, we=0, ld=0, counters=0.
//     With all slots invalid, outputs are ld_stall=0 and both selects=HAZ_FWD_RF.
//   - Slots are registered; next state is computed from current slots (a "fire" moves the current
//     contents, not next-state contents):
//       EX: id_issue -> load id_*, v=1; else ex_fire -> v=0; else hold.
//       ME: ex_fire  -> copy EX slot;   else me_fire -> v=0; else hold.
//       WB: me_fire  -> copy ME slot;   else wb_retire -> v=0; else hold.
//   - All three updates may occur in the same cycle; the whole pipeline then shifts by one.
//   - Slot match = v & we & dest!=0 & dest==addr & use. Priority is youngest first: EX > ME > WB.
//     If no slot matches, the select is HAZ_FWD_RF.
//   - ld_stall = id_valid & (EX match on rj or rkd) & EX.ld. This is combinational from the
//     registered slots and is 0 when id_valid=0. While stalled, the select still points at EX.
//   - A load in ME or WB never stalls (default build); it forwards normally.
//   - Controller latency: 0 cycles (outputs are purely combinational from slots + ID inputs).
//     Slot update latency: 1 cycle after each fire.
//   - Branch flush affects only IF/ID. No slot is cleared by flush.
//   - Protocol violations are flagged by simulation assertions only:
//       id_issue while ld_stall=1;
//       ex_fire with EX.v=0;
//       me_fire with ME.v=0.
//   - resetn asserted mid-operation: all slots are invalid the next sampled edge; no stale forwarding.
// CONFIGURATION
//   HAZ_PERF_CNT_EN defined:
//     perf_stall_cnt += 1 per cycle with ld_stall=1.
//     perf_issue_cnt += 1 per id_issue.
//     Both counters wrap at 2^CNT_W.
//   HAZ_PERF_CNT_EN undefined: counters are not built; both perf outputs are tied to 0.
// STRUCTURE
//   - Package haz_pkg: HAZ_FWD_RF=2'd0, HAZ_FWD_EX=2'd1, HAZ_FWD_ME=2'd2, HAZ_FWD_WB=2'd3;
//     slot struct typedef haz_slot_t {v, dest, we, ld}.
//   - Sub-module haz_stage_slot: one slot register with load/clear/hold controls and a
//     match output for one source address. Instantiated 3x; the top adds priority and stall logic.
// TESTING
//   1 Reset: resetn=0 mid-run with all slots valid -> next edge: selects=0, ld_stall=0, counters=0.
//   2 ALU RAW: issue add r5; next cycle rj_addr=5, rj_use=1 -> fwd_sel_rj=EX.
//     Advance one stage per cycle -> ME, then WB, then RF after retire.
//   3 Load-use: issue ld r7 (ld=1); next cycle rkd_addr=7, rkd_use=1, id_valid=1 -> ld_stall=1.
//     After ex_fire -> ld_stall=0, fwd_sel_rkd=ME.
//   4 Priority: r3 written by instrs in WB, ME and EX -> select=EX.
//     Then set EX.we=0 -> select=ME.
//   5 r0/use: dest=0 or use=0 with matching addr -> HAZ_FWD_RF, no stall.
//     st-type instr (we=0) in EX -> no match.
//   6 Simultaneous: id_issue, ex_fire, me_fire and wb_retire in one cycle -> every slot shifts
//     one stage, the WB slot's previous contents are dropped, and the new instr lands in EX.
//     With HAZ_PERF_CNT_EN: 3 stall cycles + 5 issues -> counters 3 and 5.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types for the ID-stage hazard controller: forward-select encoding and stage slot layout.
// Slot dest width is fixed here; the controller's REG_AW must agree with HAZ_REG_AW.
package haz_pkg;

    localparam int HAZ_REG_AW = 5;

    localparam logic [1:0] HAZ_FWD_RF = 2'd0;
    localparam logic [1:0] HAZ_FWD_EX = 2'd1;
    localparam logic [1:0] HAZ_FWD_ME = 2'd2;
    localparam logic [1:0] HAZ_FWD_WB = 2'd3;

    typedef struct packed {
        logic                  v;
        logic [HAZ_REG_AW-1:0] dest;
        logic                  we;
        logic                  ld;
    } haz_slot_t;

    // r0 is hard-wired zero, so it never produces a dependency.
    function automatic logic haz_slot_match(
        input haz_slot_t             slot,
        input logic [HAZ_REG_AW-1:0] addr,
        input logic                  src_use
    );
        return slot.v & slot.we & (slot.dest != '0) & (slot.dest == addr) & src_use;
    endfunction

endpackage

// File: rtl/haz_stage_slot.sv
// One pipeline-stage tracking slot {v, dest, we, ld}: load wins over clear, otherwise hold.
// Match outputs are combinational from the registered slot against the two ID source operands.
module haz_stage_slot
    import haz_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  haz_slot_t             i_din,
    input  logic [HAZ_REG_AW-1:0] i_rj_addr,
    input  logic                  i_rj_use,
    input  logic [HAZ_REG_AW-1:0] i_rkd_addr,
    input  logic                  i_rkd_use,
    output haz_slot_t             o_slot,
    output logic                  o_match_rj,
    output logic                  o_match_rkd
);

    haz_slot_t r_slot;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot <= i_din;
        end else if (i_clear) begin
            r_slot.v <= 1'b0;
        end
    end

    assign o_slot      = r_slot;
    assign o_match_rj  = haz_slot_match(r_slot, i_rj_addr, i_rj_use);
    assign o_match_rkd = haz_slot_match(r_slot, i_rkd_addr, i_rkd_use);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage load-use stall and EX/ME/WB forward-select controller; outputs are 0-cycle combinational.
// Optional perf counters (stall cycles, issues) are built only when HAZ_PERF_CNT_EN is defined.
module id_hazard_ctrl
    import haz_pkg::*;
#(
    parameter int REG_AW = HAZ_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_issue,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_gr_we,
    input  logic              id_is_load,
    input  logic              ex_fire,
    input  logic              me_fire,
    input  logic              wb_retire,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rj_addr,
    input  logic              rj_use,
    input  logic [REG_AW-1:0] rkd_addr,
    input  logic              rkd_use,
    output logic              ld_stall,
    output logic [1:0]        fwd_sel_rj,
    output logic [1:0]        fwd_sel_rkd,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_issue_cnt
);

    haz_slot_t w_ex_din;
    haz_slot_t w_ex_slot;
    haz_slot_t w_me_slot;
    haz_slot_t w_wb_slot;
    logic      w_ex_m_rj, w_ex_m_rkd;
    logic      w_me_m_rj, w_me_m_rkd;
    logic      w_wb_m_rj, w_wb_m_rkd;
    logic      w_unused_wb;

    assign w_ex_din = '{v: 1'b1, dest: id_dest, we: id_gr_we, ld: id_is_load};

    // Each stage copies its upstream neighbour's current contents, so a full shift is one edge.
    haz_stage_slot u_ex_slot (
        .clk(clk), .resetn(resetn),
        .i_load(id_issue), .i_clear(ex_fire), .i_din(w_ex_din),
        .i_rj_addr(rj_addr), .i_rj_use(rj_use), .i_rkd_addr(rkd_addr), .i_rkd_use(rkd_use),
        .o_slot(w_ex_slot), .o_match_rj(w_ex_m_rj), .o_match_rkd(w_ex_m_rkd)
    );

    haz_stage_slot u_me_slot (
        .clk(clk), .resetn(resetn),
        .i_load(ex_fire), .i_clear(me_fire), .i_din(w_ex_slot),
        .i_rj_addr(rj_addr), .i_rj_use(rj_use), .i_rkd_addr(rkd_addr), .i_rkd_use(rkd_use),
        .o_slot(w_me_slot), .o_match_rj(w_me_m_rj), .o_match_rkd(w_me_m_rkd)
    );

    haz_stage_slot u_wb_slot (
        .clk(clk), .resetn(resetn),
        .i_load(me_fire), .i_clear(wb_retire), .i_din(w_me_slot),
        .i_rj_addr(rj_addr), .i_rj_use(rj_use), .i_rkd_addr(rkd_addr), .i_rkd_use(rkd_use),
        .o_slot(w_wb_slot), .o_match_rj(w_wb_m_rj), .o_match_rkd(w_wb_m_rkd)
    );

    assign w_unused_wb = ^w_wb_slot;

    // Youngest producer wins: EX > ME > WB > regfile.
    always_comb begin
        fwd_sel_rj = HAZ_FWD_RF;
        if (w_ex_m_rj)      fwd_sel_rj = HAZ_FWD_EX;
        else if (w_me_m_rj) fwd_sel_rj = HAZ_FWD_ME;
        else if (w_wb_m_rj) fwd_sel_rj = HAZ_FWD_WB;
    end

    always_comb begin
        fwd_sel_rkd = HAZ_FWD_RF;
        if (w_ex_m_rkd)      fwd_sel_rkd = HAZ_FWD_EX;
        else if (w_me_m_rkd) fwd_sel_rkd = HAZ_FWD_ME;
        else if (w_wb_m_rkd) fwd_sel_rkd = HAZ_FWD_WB;
    end

    // Load data only exists from ME onward, so only a load still in EX forces a bubble.
    assign ld_stall = id_valid & (w_ex_m_rj | w_ex_m_rkd) & w_ex_slot.ld;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (ld_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (id_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_issue_cnt = r_issue_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_issue_cnt = '0;
`endif

    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!resetn)
        !(id_issue && ld_stall));
    a_ex_fire_valid: assert property (@(posedge clk) disable iff (!resetn)
        ex_fire |-> w_ex_slot.v);
    a_me_fire_valid: assert property (@(posedge clk) disable iff (!resetn)
        me_fire |-> w_me_slot.v);

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl; perf expectations follow HAZ_PERF_CNT_EN.
module tb_id_hazard_ctrl;
    import haz_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_issue, id_gr_we, id_is_load;
    logic [4:0]  id_dest;
    logic        ex_fire, me_fire, wb_retire, id_valid;
    logic [4:0]  rj_addr, rkd_addr;
    logic        rj_use, rkd_use;
    logic        ld_stall;
    logic [1:0]  fwd_sel_rj, fwd_sel_rkd;
    logic [31:0] perf_stall_cnt, perf_issue_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef HAZ_PERF_CNT_EN
    localparam int EXP_STALLS = 3;
    localparam int EXP_ISSUES = 5;
`else
    localparam int EXP_STALLS = 0;
    localparam int EXP_ISSUES = 0;
`endif

    always #5 clk = ~clk;

    id_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .id_issue(id_issue), .id_dest(id_dest), .id_gr_we(id_gr_we), .id_is_load(id_is_load),
        .ex_fire(ex_fire), .me_fire(me_fire), .wb_retire(wb_retire), .id_valid(id_valid),
        .rj_addr(rj_addr), .rj_use(rj_use), .rkd_addr(rkd_addr), .rkd_use(rkd_use),
        .ld_stall(ld_stall), .fwd_sel_rj(fwd_sel_rj), .fwd_sel_rkd(fwd_sel_rkd),
        .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; fire pulses last exactly one cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        id_issue = 0; ex_fire = 0; me_fire = 0; wb_retire = 0;
        #1;
    endtask

    task automatic issue(input logic [4:0] d, input logic we, input logic ld);
        id_issue = 1; id_dest = d; id_gr_we = we; id_is_load = ld;
    endtask

    task automatic set_rj(input logic [4:0] a, input logic u);
        rj_addr = a; rj_use = u; #1;
    endtask

    initial begin
        resetn = 0;
        id_issue = 0; id_dest = 0; id_gr_we = 0; id_is_load = 0;
        ex_fire = 0; me_fire = 0; wb_retire = 0;
        id_valid = 1; rj_addr = 0; rj_use = 0; rkd_addr = 0; rkd_use = 0;
        repeat (2) @(negedge clk);
        chk("rst_sel_rj", fwd_sel_rj, HAZ_FWD_RF);
        chk("rst_stall", ld_stall, 0);
        chk("rst_stall_cnt", perf_stall_cnt, 0);
        resetn = 1;
        @(negedge clk);

        // ALU RAW on r5 walking EX -> ME -> WB -> RF
        rj_addr = 5; rj_use = 1;
        issue(5, 1, 0); cyc();
        chk("raw_ex", fwd_sel_rj, HAZ_FWD_EX);
        chk("raw_ex_rkd", fwd_sel_rkd, HAZ_FWD_RF);
        chk("raw_ex_nostall", ld_stall, 0);
        ex_fire = 1; cyc();
        chk("raw_me", fwd_sel_rj, HAZ_FWD_ME);
        me_fire = 1; cyc();
        chk("raw_wb", fwd_sel_rj, HAZ_FWD_WB);
        wb_retire = 1; cyc();
        chk("raw_rf", fwd_sel_rj, HAZ_FWD_RF);

        // load-use on r7 via rkd
        rj_use = 0; rkd_addr = 7; rkd_use = 1;
        issue(7, 1, 1); cyc();
        chk("lu_stall", ld_stall, 1);
        chk("lu_sel_ex", fwd_sel_rkd, HAZ_FWD_EX);
        cyc();
        chk("lu_stall_hold", ld_stall, 1);
        ex_fire = 1; cyc();
        chk("lu_release", ld_stall, 0);
        chk("lu_sel_me", fwd_sel_rkd, HAZ_FWD_ME);
        me_fire = 1; cyc();
        wb_retire = 1; cyc();
        rkd_use = 0;

        // priority: r3 written in WB, ME and EX
        set_rj(3, 1);
        issue(3, 1, 0); cyc();
        issue(3, 1, 0); ex_fire = 1; cyc();
        issue(3, 1, 0); ex_fire = 1; me_fire = 1; cyc();
        chk("prio_ex", fwd_sel_rj, HAZ_FWD_EX);
        issue(3, 0, 0); ex_fire = 1; me_fire = 1; wb_retire = 1; cyc();
        chk("prio_me_store_ex", fwd_sel_rj, HAZ_FWD_ME);
        set_rj(3, 0);
        chk("use0_rj", fwd_sel_rj, HAZ_FWD_RF);
        rkd_addr = 3; rkd_use = 0; #1;
        chk("use0_rkd", fwd_sel_rkd, HAZ_FWD_RF);
        ex_fire = 1; me_fire = 1; wb_retire = 1; cyc();
        me_fire = 1; wb_retire = 1; cyc();
        wb_retire = 1; cyc();
        chk("drained", fwd_sel_rkd, HAZ_FWD_RF);

        // r0 destination never matches, even for a load
        issue(0, 1, 1); cyc();
        set_rj(0, 1);
        chk("r0_sel", fwd_sel_rj, HAZ_FWD_RF);
        chk("r0_nostall", ld_stall, 0);
        ex_fire = 1; cyc();
        me_fire = 1; cyc();
        wb_retire = 1; cyc();

        // load in EX with use=0, then use=1, then id_valid=0
        issue(9, 1, 1); cyc();
        set_rj(9, 0);
        rkd_addr = 9; rkd_use = 0; #1;
        chk("nouse_nostall", ld_stall, 0);
        chk("nouse_sel", fwd_sel_rkd, HAZ_FWD_RF);
        set_rj(9, 1);
        chk("use_stall", ld_stall, 1);
        id_valid = 0; #1;
        chk("novalid_nostall", ld_stall, 0);
        chk("novalid_sel_ex", fwd_sel_rj, HAZ_FWD_EX);

        // fill all stages, then async reset mid-run
        issue(10, 1, 0); ex_fire = 1; cyc();
        issue(11, 1, 0); ex_fire = 1; me_fire = 1; cyc();
        set_rj(9, 1);
        chk("full_wb", fwd_sel_rj, HAZ_FWD_WB);
        id_valid = 1;
        rkd_addr = 10; rkd_use = 1; #1;
        chk("full_me", fwd_sel_rkd, HAZ_FWD_ME);
        resetn = 0;
        @(posedge clk); #1;
        chk("mid_rst_rj", fwd_sel_rj, HAZ_FWD_RF);
        chk("mid_rst_rkd", fwd_sel_rkd, HAZ_FWD_RF);
        chk("mid_rst_stall", ld_stall, 0);
        chk("mid_rst_scnt", perf_stall_cnt, 0);
        chk("mid_rst_icnt", perf_issue_cnt, 0);
        @(negedge clk);
        resetn = 1;
        rkd_use = 0;
        @(negedge clk);
        chk("post_rst_rj", fwd_sel_rj, HAZ_FWD_RF);

        // 3 stall cycles, 5 issues, full simultaneous shifts
        set_rj(20, 1);
        issue(20, 1, 1); cyc();
        chk("sim_stall", ld_stall, 1);
        cyc();
        cyc();
        ex_fire = 1; cyc();
        chk("sim_unstall", ld_stall, 0);
        chk("sim_a_me", fwd_sel_rj, HAZ_FWD_ME);
        issue(21, 1, 0); cyc();
        issue(22, 1, 0); ex_fire = 1; me_fire = 1; cyc();
        chk("sim_a_wb", fwd_sel_rj, HAZ_FWD_WB);
        issue(23, 1, 0); ex_fire = 1; me_fire = 1; wb_retire = 1; cyc();
        chk("sim_a_dropped", fwd_sel_rj, HAZ_FWD_RF);
        set_rj(21, 1);
        chk("sim_b_wb", fwd_sel_rj, HAZ_FWD_WB);
        set_rj(22, 1);
        chk("sim_c_me", fwd_sel_rj, HAZ_FWD_ME);
        set_rj(23, 1);
        chk("sim_d_ex", fwd_sel_rj, HAZ_FWD_EX);
        issue(24, 1, 0); ex_fire = 1; me_fire = 1; wb_retire = 1; cyc();
        set_rj(21, 1);
        chk("sim2_b_dropped", fwd_sel_rj, HAZ_FWD_RF);
        set_rj(22, 1);
        chk("sim2_c_wb", fwd_sel_rj, HAZ_FWD_WB);
        set_rj(24, 1);
        chk("sim2_e_ex", fwd_sel_rj, HAZ_FWD_EX);
        chk("perf_stall", perf_stall_cnt, EXP_STALLS);
        chk("perf_issue", perf_issue_cnt, EXP_ISSUES);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
